// File: rtl/data_memory.sv
// data_memory: byte-addressable little-endian data memory with sized loads/stores, alignment check and store trace
module data_memory #(
  parameter int         DEPTH_WORDS = 3072,
  parameter logic [2:0] DM_W  = 3'b000,
  parameter logic [2:0] DM_H  = 3'b001,
  parameter logic [2:0] DM_B  = 3'b010,
  parameter logic [2:0] DM_HU = 3'b011,
  parameter logic [2:0] DM_BU = 3'b100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic        DMWr,
  input  logic [2:0]  DMOp,
  output logic [31:0] rd,
  output logic        misalign,
  output logic [31:0] store_cnt
);
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);
  logic [31:0] mem [DEPTH_WORDS];
  logic [11:0] idx;
  logic        in_range, is_h, is_b, commit;
  logic [31:0] word, wdata, merged;
  logic [15:0] half;
  logic [7:0]  byte_sel;
  logic [3:0]  be;
  assign idx      = addr[13:2];
  assign in_range = addr < LIMIT;
  assign is_h     = DMOp == DM_H || DMOp == DM_HU;
  assign is_b     = DMOp == DM_B || DMOp == DM_BU;
  assign misalign = !in_range || (!is_h && !is_b && addr[1:0] != 2'b00) || (is_h && addr[0]);
  assign word     = in_range ? mem[idx] : 32'h0;
  assign half     = word[{addr[1], 4'b0000} +: 16];
  assign byte_sel = word[{addr[1:0], 3'b000} +: 8];
  assign be       = is_b ? 4'b0001 << addr[1:0] : is_h ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata    = is_b ? {4{wd[7:0]}} : is_h ? {2{wd[15:0]}} : wd;
  assign commit   = DMWr && !misalign && !reset;
  // load extraction and extension; unknown codes fall through to a full-word load
  always_comb begin
    rd = misalign ? 32'h0 :
         DMOp == DM_B  ? {{24{byte_sel[7]}}, byte_sel} :
         DMOp == DM_BU ? {24'h0, byte_sel} :
         DMOp == DM_H  ? {{16{half[15]}}, half} :
         DMOp == DM_HU ? {16'h0, half} : word;
  end
  // merge the addressed lanes of the store into the current word
  always_comb begin
    merged = word;
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : word[8*i +: 8];
  end
  // memory and store counter; reset wipes every word and beats a simultaneous store
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++)
        mem[i] <= 32'h0;
      store_cnt <= 32'h0;
    end else if (commit) begin
      mem[idx]  <= merged;
      store_cnt <= store_cnt + 32'd1;
    end
  end
`ifndef SYNTHESIS
  // simulation-only trace of every committed store
  always_ff @(posedge clk) begin
    if (commit)
      $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged);
  end
`endif
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed and randomized checks of data_memory against a byte-level reference model
module tb_data_memory;
  localparam logic [2:0] W = 3'b000, H = 3'b001, B = 3'b010, HU = 3'b011, BU = 3'b100;
  localparam int NBYTES = 4 * 3072;
  logic        clk = 1'b0, reset = 1'b0, DMWr = 1'b0;
  logic [2:0]  DMOp = 3'b000;
  logic [31:0] pc = 32'h0, addr = 32'h0, wd = 32'h0;
  logic [31:0] rd, store_cnt;
  logic        misalign;
  int          checks = 0, errors = 0;
  logic [7:0]  bmem [NBYTES];
  logic [31:0] ref_cnt = 32'h0;

  data_memory dut (
    .clk(clk), .reset(reset), .pc(pc), .addr(addr), .wd(wd),
    .DMWr(DMWr), .DMOp(DMOp), .rd(rd), .misalign(misalign), .store_cnt(store_cnt)
  );

  always #5 clk = ~clk;

  function automatic int nbytes(input logic [2:0] op);
    return (op == H || op == HU) ? 2 : (op == B || op == BU) ? 1 : 4;
  endfunction

  function automatic logic ref_mis(input logic [2:0] op, input logic [31:0] a);
    int n = nbytes(op);
    return a >= 32'(NBYTES) || (a % 32'(n)) != 32'h0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] v = 32'h0;
    if (ref_mis(op, a)) return 32'h0;
    for (int i = 0; i < nbytes(op); i++) v[8*i +: 8] = bmem[int'(a) + i];
    if (op == H && v[15]) v = v | 32'hFFFF0000;
    if (op == B && v[7])  v = v | 32'hFFFFFF00;
    return v;
  endfunction

  task automatic drive(input logic we, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    DMWr = we; DMOp = op; addr = a; wd = d; pc = pc + 32'd4;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NBYTES; i++) bmem[i] = 8'h0;
      ref_cnt = 32'h0;
    end else if (DMWr && !ref_mis(DMOp, addr)) begin
      for (int i = 0; i < nbytes(DMOp); i++) bmem[int'(addr) + i] = wd[8*i +: 8];
      ref_cnt = ref_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    drive(1'b0, W, 32'h0, 32'h0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    drive(1'b1, W, 32'h60, 32'hCAFEF00D);
    tick();
    do_reset();
    drive(1'b0, W, 32'h60, 32'h0);
    checks++; if (store_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h want %h", store_cnt, 32'h0); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_discard got %h want %h", rd, 32'h0); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign); end
  endtask

  task automatic test_word;
    do_reset();
    drive(1'b1, W, 32'h10, 32'h800000F1);
    tick();
    drive(1'b0, W, 32'h10, 32'h0);
    checks++; if (rd !== 32'h800000F1) begin errors++; $display("FAIL word_lw got %h want %h", rd, 32'h800000F1); end
    drive(1'b0, B, 32'h10, 32'h0);
    checks++; if (rd !== 32'hFFFFFFF1) begin errors++; $display("FAIL word_lb got %h want %h", rd, 32'hFFFFFFF1); end
    drive(1'b0, BU, 32'h13, 32'h0);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL word_lbu got %h want %h", rd, 32'h00000080); end
    checks++; if (store_cnt !== 32'd1) begin errors++; $display("FAIL word_cnt got %h want %h", store_cnt, 32'd1); end
  endtask

  task automatic test_byte_merge;
    drive(1'b1, W, 32'h20, 32'h11223344);
    tick();
    drive(1'b1, B, 32'h22, 32'hFFFFFFAB);
    tick();
    drive(1'b0, W, 32'h20, 32'h0);
    checks++; if (rd !== 32'h11AB3344) begin errors++; $display("FAIL byte_merge got %h want %h", rd, 32'h11AB3344); end
  endtask

  task automatic test_half;
    drive(1'b1, W, 32'h24, 32'h55667788);
    tick();
    drive(1'b1, H, 32'h26, 32'h00009ABC);
    tick();
    drive(1'b0, W, 32'h24, 32'h0);
    checks++; if (rd !== 32'h9ABC7788) begin errors++; $display("FAIL half_word got %h want %h", rd, 32'h9ABC7788); end
    drive(1'b0, H, 32'h26, 32'h0);
    checks++; if (rd !== 32'hFFFF9ABC) begin errors++; $display("FAIL half_lh got %h want %h", rd, 32'hFFFF9ABC); end
    drive(1'b0, HU, 32'h26, 32'h0);
    checks++; if (rd !== 32'h00009ABC) begin errors++; $display("FAIL half_lhu got %h want %h", rd, 32'h00009ABC); end
  endtask

  task automatic test_misalign;
    logic [2:0]  ops [5] = '{W, H, W, B, HU};
    logic [31:0] as  [5] = '{32'h31, 32'h33, 32'(NBYTES), 32'(NBYTES + 1), 32'h35};
    logic [31:0] cnt;
    drive(1'b1, W, 32'h30, 32'hA5A5A5A5);
    tick();
    cnt = ref_cnt;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, ops[k], as[k], 32'h12345678);
      checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_flag%0d got %b want 1", k, misalign); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_rd%0d got %h want %h", k, rd, 32'h0); end
      tick();
    end
    drive(1'b0, W, 32'h30, 32'h0);
    checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL mis_mem got %h want %h", rd, 32'hA5A5A5A5); end
    checks++; if (store_cnt !== cnt) begin errors++; $display("FAIL mis_cnt got %h want %h", store_cnt, cnt); end
    drive(1'b0, W, 32'(NBYTES - 4), 32'h0);
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_lastword got %b want 0", misalign); end
  endtask

  task automatic test_rdw;
    drive(1'b1, W, 32'h40, 32'h1);
    tick();
    drive(1'b1, W, 32'h40, 32'hDEADBEEF);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL rdw_old got %h want %h", rd, 32'h1); end
    tick();
    drive(1'b0, W, 32'h40, 32'h0);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rdw_new got %h want %h", rd, 32'hDEADBEEF); end
  endtask

  task automatic test_reset_priority;
    reset = 1'b1;
    drive(1'b1, W, 32'h50, 32'h13572468);
    tick();
    reset = 1'b0;
    drive(1'b0, W, 32'h50, 32'h0);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rstpri_rd got %h want %h", rd, 32'h0); end
    checks++; if (store_cnt !== 32'h0) begin errors++; $display("FAIL rstpri_cnt got %h want %h", store_cnt, 32'h0); end
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a;
    for (int n = 0; n < 400; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 9) == 0) ? 32'(NBYTES - 8 + int'($urandom_range(0, 15))) : 32'($urandom_range(0, 127));
      drive(1'($urandom_range(0, 1)), op, a, $urandom);
      checks++; if (rd !== ref_load(op, a)) begin errors++; $display("FAIL rand_rd op=%0d a=%h got %h want %h", op, a, rd, ref_load(op, a)); end
      checks++; if (misalign !== ref_mis(op, a)) begin errors++; $display("FAIL rand_mis op=%0d a=%h got %b want %b", op, a, misalign, ref_mis(op, a)); end
      checks++; if (store_cnt !== ref_cnt) begin errors++; $display("FAIL rand_cnt got %h want %h", store_cnt, ref_cnt); end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < NBYTES; i++) bmem[i] = 8'h0;
    test_reset();
    test_word();
    test_byte_merge();
    test_half();
    test_misalign();
    test_rdw();
    test_reset_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DEPTH_WORDS, default 3072, sets the number of 32-bit words stored.
REQ-002 Parameter DM_W=3'b000, DM_H=3'b001, DM_B=3'b010, DM_HU=3'b011, DM_BU=3'b100 set the access-width codes, matching the control unit's DMOp encoding.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc  input  32  PC of the instruction issuing the access; used only for the store trace.
REQ-006 addr  input  32  byte address from the ALU.
REQ-007 wd  input  32  store data, right-aligned (byte in wd[7:0], half in wd[15:0]).
REQ-008 DMWr  input  1  store enable for the current cycle.
REQ-009 DMOp  input  3  access width/extension code per REQ-002.
REQ-010 rd  output  32  load data, already extended.
REQ-011 misalign  output  1  current access violates alignment or range.
REQ-012 store_cnt  output  32  count of committed stores since reset.

Function
REQ-013 The word index SHALL be addr[13:2], and the byte lane SHALL be addr[1:0]; memory is little-endian, so byte lane 0 maps to bits [7:0].
REQ-014 rd SHALL be combinational from the current addr/DMOp and stored contents.
REQ-015 For DM_W, rd SHALL be the full word.
REQ-016 For DM_H, rd SHALL be the half selected by addr[1], sign-extended.
REQ-017 For DM_HU, rd SHALL be the half selected by addr[1], zero-extended.
REQ-018 For DM_B, rd SHALL be the byte selected by addr[1:0], sign-extended.
REQ-019 For DM_BU, rd SHALL be the byte selected by addr[1:0], zero-extended.
REQ-020 Any other DMOp value SHALL be treated as DM_W.
REQ-021 misalign SHALL be 1 when any of the following holds: DMOp in {DM_W} with addr[1:0]!=0; DMOp in {DM_H,DM_HU} with addr[0]!=0; addr >= 4*DEPTH_WORDS.
REQ-022 When misalign=1, rd SHALL be 32'h0 (no partial data).
REQ-023 A store SHALL commit on the rising clk edge when DMWr=1, reset=0 and misalign=0.
REQ-024 A committed store SHALL update only the addressed lanes: DM_W writes 4 bytes; DM_H/DM_HU write 2 bytes at addr[1]; DM_B/DM_BU write 1 byte at addr[1:0].
REQ-025 Unaddressed bytes of the word SHALL retain their previous value.
REQ-026 A store blocked by misalign SHALL leave memory and store_cnt unchanged.
REQ-027 Read-during-write: in the store cycle, rd SHALL show pre-write contents; post-write contents SHALL be visible from the next cycle.
REQ-028 store_cnt SHALL increment by 1 per committed store.
REQ-029 store_cnt SHALL wrap from 32'hFFFFFFFF to 0 without flagging.
REQ-030 Each committed store SHALL emit a simulation trace line "@<pc hex>: *<word byte address hex> <= <full merged word hex>", where the word byte address has addr[1:0] forced to 0; the trace SHALL be non-synthesizable.
REQ-031 The trace format SHALL be identical for byte, half and word stores.

Reset
REQ-032 When reset=1 at a rising edge, every memory word SHALL become 32'h0 and store_cnt SHALL become 0.
REQ-033 reset SHALL take priority over a simultaneous DMWr=1: no store commits, no trace is printed, and the counter does not increment.
REQ-034 rd and misalign SHALL need no reset, being combinational; after reset, any in-range aligned load SHALL return 0.
REQ-035 Reset asserted mid-program SHALL discard all prior stores, with no partial retention.

Verification
REQ-036 Word store/load: reset; DM_W store of 32'h8000_00F1 to addr 0x10 -> next cycle, DM_W load at 0x10 gives 32'h800000F1, DM_B load at 0x10 gives 32'hFFFFFFF1, DM_BU load at 0x13 gives 32'h00000080, store_cnt=1.
REQ-037 Byte merge: the word at 0x20 holds 32'h11223344; DM_B store of wd=32'hAB to 0x22 -> word becomes 32'h11AB3344, trace prints the full merged word.
REQ-038 Half store/load: DM_H store of wd=32'h0000_9ABC to 0x26 -> word at 0x24 has [31:16]=16'h9ABC; DM_H load at 0x26 gives 32'hFFFF9ABC; DM_HU load at 0x26 gives 32'h00009ABC.
REQ-039 Misalign: DM_W store to 0x31, or DM_H store to 0x33, or a store to addr 4*DEPTH_WORDS -> misalign=1, memory unchanged, store_cnt unchanged, no trace, rd=0.
REQ-040 Read-during-write: a DM_W store of 32'hDEADBEEF to 0x40 over old value 32'h1 -> rd=32'h1 in the store cycle and 32'hDEADBEEF in the following cycle.
REQ-041 Reset priority: reset=1 with DMWr=1 to 0x50 -> the 0x50 load returns 0 afterwards and store_cnt=0.
